// File: rtl/my_multicycle_shifter_pkg.sv
// Shared encodings and stage constants for the multicycle barrel shifter.
// Five log-stages (16,8,4,2,1), one per cycle.
package my_multicycle_shifter_pkg;

  localparam int SHIFT_W    = 32;
  localparam int NUM_STAGES = 5;
  localparam logic [2:0] LAST_STAGE = 3'(NUM_STAGES - 1);

  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRL  = 2'b01,
    OP_SRA  = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [4:0] STAGE_AMT_16 = 5'd16;
  localparam logic [4:0] STAGE_AMT_8  = 5'd8;
  localparam logic [4:0] STAGE_AMT_4  = 5'd4;
  localparam logic [4:0] STAGE_AMT_2  = 5'd2;
  localparam logic [4:0] STAGE_AMT_1  = 5'd1;

  function automatic logic [4:0] stage_amt(input logic [2:0] cnt);
    case (cnt)
      3'd0:    stage_amt = STAGE_AMT_16;
      3'd1:    stage_amt = STAGE_AMT_8;
      3'd2:    stage_amt = STAGE_AMT_4;
      3'd3:    stage_amt = STAGE_AMT_2;
      default: stage_amt = STAGE_AMT_1;
    endcase
  endfunction

endpackage

// File: rtl/my_shift_stage.sv
// One combinational shifter stage: amount chosen by stage counter, enabled by
// the matching shamt bit (counter 0 -> shamt[4]); zero latency, no flow control.
module my_shift_stage
  import my_multicycle_shifter_pkg::*;
(
  input  logic [SHIFT_W-1:0] i_data,
  input  logic [2:0]         i_cnt,
  input  logic [4:0]         i_shamt,
  input  op_e                i_op,
  output logic [SHIFT_W-1:0] o_data
);

  logic       w_en;
  logic [4:0] w_amt;

  always_comb begin
    w_en  = |(i_shamt & (5'b10000 >> i_cnt));
    w_amt = w_en ? stage_amt(i_cnt) : 5'd0;
    case (i_op)
      OP_SLL:  o_data = i_data << w_amt;
      OP_SRL:  o_data = i_data >> w_amt;
      // bit 31 is preserved by every arithmetic stage, so it stays the captured sign
      OP_SRA:  o_data = SHIFT_W'($signed(i_data) >>> w_amt);
      default: o_data = i_data;
    endcase
  end

endmodule

// File: rtl/my_multicycle_shifter.sv
// Multicycle SLL/SRL/SRA shifter: result 5 edges after accept, held until out_ready.
// in_ready only in IDLE, so one operation in flight; issue interval 7 cycles.
module my_multicycle_shifter
  import my_multicycle_shifter_pkg::*;
#(
  parameter int DATA_W = SHIFT_W
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in,
  input  logic [4:0]        shamt,
  input  logic [1:0]        op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              busy
);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [2:0]         r_cnt;
  logic [DATA_W-1:0]  r_work;
  logic [4:0]         r_shamt;
  op_e                r_op;
  logic [DATA_W-1:0]  w_stage_out;
  logic               w_accept;

  my_shift_stage u_stage (
    .i_data  (r_work),
    .i_cnt   (r_cnt),
    .i_shamt (r_shamt),
    .i_op    (r_op),
    .o_data  (w_stage_out)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        w_accept = in_valid;
        if (in_valid) w_state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (r_cnt == LAST_STAGE) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Working register doubles as the result register until the next accept.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_cnt   <= 3'd0;
      r_work  <= '0;
      r_shamt <= 5'd0;
      r_op    <= OP_SLL;
    end else if (w_accept) begin
      r_cnt   <= 3'd0;
      r_work  <= data_in;
      r_shamt <= shamt;
      r_op    <= op_e'(op);
    end else if (r_state == ST_SHIFT) begin
      r_cnt   <= r_cnt + 3'd1;
      r_work  <= w_stage_out;
    end
  end

  assign data_out = r_work;

endmodule

// File: tb/tb_my_multicycle_shifter.sv
// Scoreboard bench for my_multicycle_shifter: accepts push a reference result,
// a negedge monitor checks latency, stability, ordering and data.
module tb_my_multicycle_shifter;

  typedef struct {
    logic [31:0] exp;
    int          acc_cyc;
  } sb_t;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] data_in = '0;
  logic [4:0]  shamt = '0;
  logic [1:0]  op = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] data_out;
  logic        busy;

  int  n_cmp = 0;
  int  n_bad = 0;
  int  cyc = 0;
  sb_t sb[$];
  bit  b2b = 0;
  int  last_acc = -1;

  my_multicycle_shifter #(.DATA_W(32)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .shamt     (shamt),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .busy      (busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] s,
                                            input logic [1:0] o);
    logic signed [31:0] sd;
    sd = d;
    case (o)
      2'b00:   return d << s;
      2'b01:   return d >> s;
      2'b10:   return 32'(sd >>> s);
      default: return d;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Monitor: records accepts into the scoreboard and checks every presented result.
  logic        prev_v = 0;
  logic        prev_r = 0;
  logic [31:0] prev_d = '0;
  always @(negedge clock) begin
    if (!resetn) begin
      prev_v = 0;
    end else begin
      check("ready_vs_busy", {31'd0, in_ready}, {31'd0, !busy});
      if (in_valid && in_ready) begin
        sb.push_back('{exp: ref_shift(data_in, shamt, op), acc_cyc: cyc + 1});
        if (b2b && last_acc >= 0) check("b2b_interval", 32'(cyc + 1 - last_acc), 32'd7);
        last_acc = cyc + 1;
      end
      if (out_valid) begin
        if (!prev_v) begin
          if (sb.size() == 0) fail_now("unexpected_result");
          else check("latency", 32'(cyc - sb[0].acc_cyc), 32'd5);
        end else if (!prev_r) begin
          check("hold_stable", data_out, prev_d);
        end
        if (out_ready) begin
          if (sb.size() == 0) fail_now("result_without_request");
          else begin
            check("result", data_out, sb[0].exp);
            void'(sb.pop_front());
          end
        end
      end
      prev_v = out_valid;
      prev_r = out_ready;
      prev_d = data_out;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [31:0] d, input logic [4:0] s, input logic [1:0] o);
    int n;
    data_in = d; shamt = s; op = o; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin step(); n++; end
    if (!in_ready) fail_now("issue_timeout");
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 100) begin step(); n++; end
    if (sb.size() != 0 || busy) fail_now("drain_timeout");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    int n;

    // Reset state
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_data_out", data_out, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    step(); step();
    resetn = 1'b1;
    step();

    // Directed vectors
    issue(32'h0000_0001, 5'd31, 2'b00); wait_idle();
    issue(32'h8000_0000, 5'd4,  2'b10); wait_idle();
    issue(32'h8000_0000, 5'd4,  2'b01); wait_idle();
    issue(32'hDEAD_BEEF, 5'd0,  2'b00); wait_idle();
    issue(32'hDEAD_BEEF, 5'd7,  2'b11); wait_idle();
    issue(32'hF000_000F, 5'd31, 2'b10); wait_idle();
    check("result_held_after_done", data_out, ref_shift(32'hF000_000F, 5'd31, 2'b10));

    // Backpressure
    out_ready = 1'b0;
    issue(32'h1234_5678, 5'd13, 2'b01);
    n = 0;
    while (!out_valid && n < 20) begin step(); n++; end
    if (!out_valid) fail_now("bp_wait_valid");
    held = data_out;
    repeat (3) begin
      step();
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_data", data_out, held);
    end
    out_ready = 1'b1;
    step();
    check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    check("bp_release_valid", {31'd0, out_valid}, 32'd0);
    wait_idle();

    // Reset during the third SHIFT cycle aborts the operation
    issue(32'hCAFE_F00D, 5'd9, 2'b00);
    step(); step();
    #1;
    resetn = 1'b0;
    #1;
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_data_out", data_out, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    sb.delete();
    data_in = 32'h0F0F_0F0F; shamt = 5'd3; op = 2'b01; in_valid = 1'b1;
    step();
    resetn = 1'b1;
    step();
    check("accept_after_reset", {31'd0, busy}, 32'd1);
    in_valid = 1'b0;
    wait_idle();

    // Back-to-back with in_valid held high
    b2b = 1; last_acc = -1;
    in_valid = 1'b1; out_ready = 1'b1;
    repeat (45) begin
      data_in = $urandom; shamt = 5'($urandom_range(0, 31)); op = 2'($urandom_range(0, 3));
      step();
    end
    in_valid = 1'b0;
    b2b = 0;
    wait_idle();

    // Random traffic, including input churn while busy
    repeat (400) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      data_in   = $urandom;
      shamt     = 5'($urandom_range(0, 31));
      op        = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/my_multicycle_shifter.md
MY_MULTICYCLE_SHIFTER -- requirements
Module: my_multicycle_shifter

Interface
REQ-001 Parameter: DATA_W, 32, datapath width; only 32 is supported.
REQ-002 clock  input  1  single clock; all state updates on the rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  upstream presents an operation.
REQ-005 in_ready  output  1  shifter can accept an operation this cycle.
REQ-006 data_in  input  32  operand to shift.
REQ-007 shamt  input  5  shift amount, 0..31.
REQ-008 op  input  2  shift type: 00 SLL, 01 SRL, 10 SRA, 11 reserved.
REQ-009 out_valid  output  1  data_out holds a completed result.
REQ-010 out_ready  input  1  downstream consumes the result.
REQ-011 data_out  output  32  shifted result.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-014 in_ready SHALL be high only in IDLE, decoded combinationally from state.
REQ-015 In IDLE, in_valid=1 SHALL capture data_in, shamt and op at the edge, clear the stage counter to 0 and enter SHIFT.
REQ-016 In SHIFT, each cycle SHALL apply one stage of amount 16, 8, 4, 2, 1 for counter 0..4.
REQ-017 A stage's shift SHALL be applied only when its shamt bit is 1 (shamt[4] for 16 ... shamt[0] for 1); otherwise the stage passes the value through.
REQ-018 All five stages SHALL always execute, giving a fixed latency that does not depend on shamt.
REQ-019 After the stage with counter 4, the FSM SHALL enter DONE, so out_valid rises exactly 5 edges after the accept edge.
REQ-020 Fill rules: SLL fills vacated bits with 0 at the LSB end; SRL fills 0 at the MSB end; SRA replicates the captured bit 31.
REQ-021 op=11 SHALL return the captured operand unchanged, with the same 5-cycle latency.
REQ-022 out_valid SHALL be high only in DONE.
REQ-023 data_out SHALL stay stable while out_valid=1 and out_ready=0.
REQ-024 In DONE, out_ready=1 SHALL return the FSM to IDLE at that edge; the earliest next accept is the following cycle.
REQ-025 Minimum issue interval SHALL be 7 cycles: accept, 5 SHIFT cycles, and one DONE cycle.
REQ-026 in_valid, data_in, shamt and op SHALL be ignored outside IDLE; captured values are never overwritten mid-operation.
REQ-027 data_out SHALL be driven from the working register, which holds the last result after DONE until the next accept.

Reset
REQ-028 resetn=0 SHALL immediately force state IDLE, stage counter 0, working register 0 and captured controls 0.
REQ-029 Reset SHALL force outputs to out_valid=0, busy=0, data_out=0, in_ready=1.
REQ-030 Reset asserted during SHIFT or DONE SHALL abort the operation and produce no result.
REQ-031 After resetn deasserts, the block SHALL accept an operation on the next edge if in_valid=1.

Structure
REQ-032 A shared package SHALL hold:
- op encodings (SLL, SRL, SRA, RSVD);
- FSM state encoding;
- the stage-amount constants 16, 8, 4, 2, 1.
REQ-033 One sub-module, my_shift_stage, SHALL be used. It is combinational, and shift amount, direction and arithmetic fill are selected per cycle by the stage counter and op.

Verification
REQ-034 SLL, data_in=0x00000001, shamt=31 -> data_out=0x80000000, out_valid high 5 cycles after the accept edge.
REQ-035 SRA, data_in=0x80000000, shamt=4 -> 0xF8000000; SRL with the same inputs -> 0x08000000.
REQ-036 SLL, data_in=0xDEADBEEF, shamt=0 -> 0xDEADBEEF with unchanged 5-cycle latency; op=11, shamt=7 -> 0xDEADBEEF.
REQ-037 Backpressure: result ready, out_ready=0 for 3 cycles:
- data_out stays stable, out_valid=1, in_ready=0;
- then out_ready=1 -> IDLE, in_ready=1 on the next cycle.
REQ-038 resetn pulsed low during the third SHIFT cycle -> out_valid=0, data_out=0 and busy=0 at once, and no result is ever presented.
REQ-039 Back-to-back: in_valid held high with out_ready=1 -> accepts occur exactly 7 cycles apart.
